// File: rtl/pipe_pkg.sv
// Shared encodings for the iterative multiply/divide unit, plus the sign-fix
// negation helper used by both the multiply and divide result paths.
package pipe_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10
    } state_e;

    // Widest operand supported by sign_fix; callers size-cast in and out.
    localparam int MAX_W = 64;

    function automatic logic [2*MAX_W-1:0] sign_fix(input logic [2*MAX_W-1:0] v,
                                                    input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/pipe_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// One radix-2 step per CALC cycle; signed ops work on magnitudes and fix signs at commit.
module pipe_muldiv
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             w_hi,
    input  logic             w_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_e             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               is_div_q, q_neg, r_neg, dz_q;
    logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
    logic [WIDTH-1:0]   opnd_b, a_mag, b_mag, quo_fix, rem_fix, res_hi, res_lo;
    logic [WIDTH:0]     msum, dshift, ddiff;
    logic               sign_a, sign_b, accept, commit;

    assign sign_a = ~op[0] & a[WIDTH-1];
    assign sign_b = ~op[0] & b[WIDTH-1];
    assign a_mag  = WIDTH'(sign_fix((2*MAX_W)'(a), sign_a));
    assign b_mag  = WIDTH'(sign_fix((2*MAX_W)'(b), sign_b));

    assign accept = (state == IDLE) && start && !flush;
    assign commit = (state == CALC) && !flush && (cnt == '0);
    assign busy   = (state != IDLE);
    assign done   = (state == FIN);
    assign dz     = done & dz_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !flush) state_nxt = CALC;
            CALC:    if (flush) state_nxt = IDLE;
                     else if (cnt == '0) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // acc holds {partial product hi, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_b} : '0);
        dshift = acc[2*WIDTH-1:WIDTH-1];
        ddiff  = dshift - {1'b0, opnd_b};
        if (is_div_q)
            acc_step = ddiff[WIDTH] ? {dshift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {ddiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_step = {msum, acc[WIDTH-1:1]};
    end

    // Divide-by-zero falls out as quotient all ones, remainder |a|; r_neg restores a.
    always_comb begin
        prod_fix = (2*WIDTH)'(sign_fix((2*MAX_W)'(acc_step), q_neg));
        quo_fix  = WIDTH'(sign_fix((2*MAX_W)'(acc_step[WIDTH-1:0]), q_neg));
        rem_fix  = WIDTH'(sign_fix((2*MAX_W)'(acc_step[2*WIDTH-1:WIDTH]), r_neg));
        if (is_div_q) begin
            res_hi = rem_fix;
            res_lo = dz_q ? '1 : quo_fix;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            is_div_q <= 1'b0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            dz_q     <= 1'b0;
            acc      <= '0;
            opnd_b   <= '0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            if (accept) begin
                cnt      <= CW'(WIDTH-1);
                is_div_q <= op[1];
                q_neg    <= sign_a ^ sign_b;
                r_neg    <= sign_a;
                dz_q     <= op[1] & (b == '0);
                acc      <= {{WIDTH{1'b0}}, a_mag};
                opnd_b   <= b_mag;
            end else if (state == CALC) begin
                acc <= acc_step;
                if (flush)            cnt <= '0;
                else if (cnt != '0)   cnt <= cnt - 1'b1;
            end
            if (commit) begin
                hi <= res_hi;
                lo <= res_lo;
            end else begin
                if (w_hi) hi <= wdata;
                if (w_lo) lo <= wdata;
            end
        end
    end

endmodule
